// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the ethernet parser ingress path.
package eth_parser_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int unsigned MAX_INGRESS_PORTS = 16;

  // Round-robin successor of idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/eth_ingress_arbiter_picker.sv
// Round-robin priority picker: lowest set request at or above ptr, wrapping.
module rr_priority_picker
  import eth_parser_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] masked;

  // Upper copy of req supplies the wrapped-around candidates below ptr.
  always_comb begin
    req_dbl = {req, req};
    masked  = '0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      masked[i] = req_dbl[i] && (i >= 32'(ptr));
    end
  end

  // Descending scan: the last hit written is the lowest set bit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 2 * N; i > 0; i--) begin
      if (masked[i-1]) begin
        found = 1'b1;
        idx   = W'((i - 1) % N);
      end
    end
  end

endmodule

// File: rtl/eth_ingress_arbiter.sv
// Frame-granular round-robin arbiter merging NUM_PORTS AXI4-Stream ingress
// ports onto the single ethernet_frame_parser input, tagging frames by port.
module eth_ingress_arbiter
  import eth_parser_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned NUM_PORTS  = 4,
  localparam int unsigned PORT_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  input  logic [NUM_PORTS-1:0]            port_enable,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [PORT_W-1:0]               m_axis_tid,
  output logic                            grant_active,
  output logic                            frame_done,
  output logic [PORT_W-1:0]               frame_done_port
);

  arb_state_t             state;
  logic [PORT_W-1:0]      grant;
  logic [PORT_W-1:0]      rr_ptr;
  logic [NUM_PORTS-1:0]   req;
  logic                   pick_found;
  logic [PORT_W-1:0]      pick_idx;
  logic                   lock;
  logic                   beat_accept;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_valid;
  logic                   sel_last;

  // Enable mask only matters while choosing a winner; the grant ignores it.
  assign req = s_axis_tvalid & port_enable;

  rr_priority_picker #(
    .N (NUM_PORTS),
    .W (PORT_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign lock         = (state == ARB_LOCK);
  assign beat_accept  = m_axis_tvalid & m_axis_tready;
  assign m_axis_tid   = grant;
  assign grant_active = lock;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (PORT_W'(i) == grant) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  always_comb begin
    m_axis_tdata  = lock ? sel_data : '0;
    m_axis_tvalid = lock & sel_valid;
    m_axis_tlast  = lock & sel_last;
    s_axis_tready = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      s_axis_tready[i] = lock && (PORT_W'(i) == grant) && m_axis_tready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ARB_IDLE;
      grant           <= '0;
      rr_ptr          <= '0;
      frame_done      <= 1'b0;
      frame_done_port <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant  <= pick_idx;
            rr_ptr <= PORT_W'(rr_next(32'(pick_idx), NUM_PORTS));
            state  <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (beat_accept && m_axis_tlast) begin
            state           <= ARB_IDLE;
            frame_done      <= 1'b1;
            frame_done_port <= grant;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_ingress_arbiter.sv
// Bench for eth_ingress_arbiter: frame-level reference model plus directed scenarios.
module tb_eth_ingress_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    s_tlast = '0;
  logic [N-1:0]    port_enable = '1;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic [PW-1:0]   m_tid;
  logic            ga;
  logic            fd;
  logic [PW-1:0]   fdp;

  always #5 clk = ~clk;

  eth_ingress_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_PORTS  (N)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tlast    (s_tlast),
    .port_enable     (port_enable),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tlast    (m_tlast),
    .m_axis_tid      (m_tid),
    .grant_active    (ga),
    .frame_done      (fd),
    .frame_done_port (fdp)
  );

  typedef struct {
    logic [63:0] data;
    bit          last;
    int          hold;
  } beat_t;

  typedef struct {
    int          tid;
    logic [63:0] data;
    bit          last;
  } obs_t;

  beat_t    srcq[N][$];
  obs_t     obs_beats[$];
  int       obs_done[$];
  bit [N-1:0] acc = '0;
  bit       tog = 1'b0;
  bit       rdy_base = 1'b1;
  int       checks = 0;
  int       errors = 0;
  int       cyc_valid = 0;
  int       cyc_grant = 0;

  // Reference model: who owns the output, and the round-robin search start.
  int owner = -1;
  int tid_m = 0;
  int next_start = 0;
  bit exp_done = 1'b0;
  int exp_done_port = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1; tid_m = 0; next_start = 0; exp_done = 1'b0; exp_done_port = 0;
    end else begin
      exp_done = 1'b0;
      if (owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int p;
          p = (next_start + k) % N;
          if (owner < 0 && s_tvalid[p] && port_enable[p]) owner = p;
        end
        if (owner >= 0) begin
          tid_m = owner;
          next_start = (owner + 1) % N;
        end
      end else if (s_tvalid[owner] && m_tready && s_tlast[owner]) begin
        exp_done = 1'b1;
        exp_done_port = owner;
        owner = -1;
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive sources after the edge, compare and observe on the falling edge.
  task automatic step();
    beat_t       b;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] exp_data;
    bit            exp_v, exp_l, exp_ga;
    @(posedge clk);
    #1;
    m_tready = tog ? ~m_tready : rdy_base;
    for (int p = 0; p < N; p++) begin
      if (acc[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
      if (srcq[p].size() == 0) begin
        s_tvalid[p] = 1'b0; s_tlast[p] = 1'b0; s_tdata[p*DW +: DW] = '0;
      end else if (srcq[p][0].hold > 0) begin
        b = srcq[p][0]; b.hold--; srcq[p][0] = b;
        s_tvalid[p] = 1'b0; s_tlast[p] = 1'b0; s_tdata[p*DW +: DW] = '0;
      end else begin
        s_tvalid[p] = 1'b1; s_tlast[p] = srcq[p][0].last; s_tdata[p*DW +: DW] = srcq[p][0].data;
      end
    end
    @(negedge clk);
    exp_rdy = '0; exp_data = '0; exp_v = 1'b0; exp_l = 1'b0; exp_ga = 1'b0;
    if (owner >= 0) begin
      exp_v = s_tvalid[owner];
      exp_l = s_tlast[owner];
      exp_data = s_tdata[owner*DW +: DW];
      exp_rdy[owner] = m_tready;
      exp_ga = 1'b1;
    end
    cmp("m_tvalid", 64'(m_tvalid), 64'(exp_v));
    cmp("m_tlast", 64'(m_tlast), 64'(exp_l));
    cmp("m_tdata", m_tdata, exp_data);
    cmp("s_tready", 64'(s_tready), 64'(exp_rdy));
    cmp("grant_active", 64'(ga), 64'(exp_ga));
    cmp("m_tid", 64'(m_tid), 64'(tid_m));
    cmp("frame_done", 64'(fd), 64'(exp_done));
    cmp("frame_done_port", 64'(fdp), 64'(exp_done_port));
    acc = s_tvalid & s_tready;
    if (m_tvalid && m_tready) obs_beats.push_back('{int'(m_tid), m_tdata, m_tlast});
    if (fd) obs_done.push_back(int'(fdp));
    if (|(s_tvalid & port_enable)) cyc_valid++;
    if (ga) cyc_grant++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    obs_done.delete(); obs_beats.delete(); cyc_valid = 0; cyc_grant = 0;
  endtask

  task automatic push_frame(input int p, input int f, input int n);
    for (int b = 0; b < n; b++) srcq[p].push_back('{64'(p*256 + f*16 + b), (b == n-1), 0});
  endtask

  task automatic wait_done(input string name, input int n, input int budget);
    int i;
    i = 0;
    while (obs_done.size() < n && i < budget) begin step(); i++; end
    cmp({name, " done_within_budget"}, 64'(obs_done.size() >= n), 64'(1));
    steps(3);
  endtask

  task automatic wait_grant(input int tid, input int budget);
    int i;
    i = 0;
    while (!(ga && int'(m_tid) == tid) && i < budget) begin step(); i++; end
    cmp("grant_within_budget", 64'(ga && int'(m_tid) == tid), 64'(1));
  endtask

  task automatic check_done(input string name, input int n, input int e0, input int e1,
                            input int e2, input int e3);
    int e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    cmp({name, " done_count"}, 64'(obs_done.size()), 64'(n));
    for (int i = 0; i < n && i < obs_done.size(); i++)
      cmp($sformatf("%s done[%0d]", name, i), 64'(obs_done[i]), 64'(e[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t t1q[$];
    // Reset state
    steps(3);
    cmp("rst m_tvalid", 64'(m_tvalid), 0);
    cmp("rst s_tready", 64'(s_tready), 0);
    cmp("rst m_tid", 64'(m_tid), 0);
    cmp("rst grant_active", 64'(ga), 0);
    cmp("rst frame_done", 64'(fd), 0);
    cmp("rst frame_done_port", 64'(fdp), 0);
    #2 rst_n = 1'b1;
    steps(2);

    // All four ports, 3-beat frames: round-robin 0,1,2,3 with one bubble each
    clear_obs();
    for (int p = 0; p < N; p++) push_frame(p, 0, 3);
    wait_done("rr4", 4, 40);
    check_done("rr4", 4, 0, 1, 2, 3);
    cmp("rr4 beats", 64'(obs_beats.size()), 12);
    for (int i = 0; i < obs_beats.size() && i < 12; i++) begin
      cmp($sformatf("rr4 tid[%0d]", i), 64'(obs_beats[i].tid), 64'(i / 3));
      cmp($sformatf("rr4 last[%0d]", i), 64'(obs_beats[i].last), 64'((i % 3) == 2));
    end
    cmp("rr4 valid cycles", 64'(cyc_valid), 16);
    cmp("rr4 grant cycles", 64'(cyc_grant), 12);

    // Port 2 alone, five single-beat frames: two cycles per frame
    clear_obs();
    for (int f = 0; f < 5; f++) push_frame(2, f, 1);
    wait_done("single", 5, 40);
    check_done("single", 5, 2, 2, 2, 2);
    if (obs_done.size() == 5) cmp("single done[4]", 64'(obs_done[4]), 2);
    cmp("single valid cycles", 64'(cyc_valid), 10);
    cmp("single grant cycles", 64'(cyc_grant), 5);

    // Port 1, 4 beats with tvalid gaps and toggling tready; 3 and 0 queue behind it
    clear_obs();
    tog = 1'b1;
    srcq[1].push_back('{64'h110, 1'b0, 0});
    srcq[1].push_back('{64'h111, 1'b0, 2});
    srcq[1].push_back('{64'h112, 1'b0, 0});
    srcq[1].push_back('{64'h113, 1'b1, 1});
    wait_grant(1, 10);
    push_frame(3, 3, 2);
    push_frame(0, 3, 2);
    wait_done("gaps", 3, 60);
    check_done("gaps", 3, 1, 3, 0, 0);
    t1q = obs_beats.find(x) with (x.tid == 1);
    cmp("gaps p1 beats", 64'(t1q.size()), 4);
    if (t1q.size() == 4) begin
      cmp("gaps d0", t1q[0].data, 64'h110);
      cmp("gaps d1", t1q[1].data, 64'h111);
      cmp("gaps d2", t1q[2].data, 64'h112);
      cmp("gaps d3", t1q[3].data, 64'h113);
      cmp("gaps last", 64'({t1q[0].last, t1q[1].last, t1q[2].last, t1q[3].last}), 64'b0001);
    end
    tog = 1'b0;
    rdy_base = 1'b1;

    // Enable mask 1101: port 1 keeps requesting but is never granted
    clear_obs();
    port_enable = 4'b1101;
    push_frame(0, 4, 2);
    push_frame(1, 4, 2);
    push_frame(2, 4, 1);
    push_frame(3, 4, 1);
    wait_done("mask", 3, 40);
    steps(8);
    check_done("mask", 3, 2, 3, 0, 0);
    cmp("mask p1 beats", 64'(obs_beats.find(x) with (x.tid == 1).size()), 0);

    // Disable port 0 mid-frame: its frame completes, then it is skipped
    clear_obs();
    push_frame(0, 5, 3);
    wait_grant(0, 10);
    port_enable = 4'b1100;
    push_frame(2, 5, 1);
    push_frame(3, 5, 1);
    push_frame(0, 6, 1);
    wait_done("disable", 3, 40);
    steps(8);
    check_done("disable", 3, 0, 2, 3, 0);
    cmp("disable p0 beats", 64'(obs_beats.find(x) with (x.tid == 0).size()), 3);
    clear_obs();
    port_enable = 4'b1111;
    wait_done("reenable", 2, 30);
    check_done("reenable", 2, 0, 1, 0, 0);

    // Pointer wrap: after a grant to 3, port 0 beats port 3
    clear_obs();
    push_frame(3, 7, 1);
    wait_done("wrap_a", 1, 20);
    check_done("wrap_a", 1, 3, 0, 0, 0);
    clear_obs();
    push_frame(0, 7, 1);
    push_frame(3, 8, 1);
    wait_done("wrap_b", 2, 20);
    check_done("wrap_b", 2, 0, 3, 0, 0);

    // Reset during a port 2 frame
    clear_obs();
    rdy_base = 1'b0;
    push_frame(2, 8, 4);
    steps(1);
    wait_grant(2, 10);
    cmp("pre-rst m_tid", 64'(m_tid), 2);
    #2 rst_n = 1'b0;
    for (int p = 0; p < N; p++) srcq[p].delete();
    step();
    cmp("midrst s_tready", 64'(s_tready), 0);
    cmp("midrst m_tvalid", 64'(m_tvalid), 0);
    cmp("midrst m_tid", 64'(m_tid), 0);
    cmp("midrst grant_active", 64'(ga), 0);
    step();
    #2 rst_n = 1'b1;
    rdy_base = 1'b1;
    step();
    clear_obs();
    push_frame(1, 9, 1);
    push_frame(2, 9, 1);
    wait_done("post_rst", 2, 20);
    check_done("post_rst", 2, 1, 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_ingress_arbiter.md
Name: eth_ingress_arbiter

Overview:
- Shares one ethernet_frame_parser AXI4-Stream input between NUM_PORTS ingress ports.
- Arbitration is frame-granular round-robin: a port keeps the grant from its first beat until its tlast beat is accepted. Frames are never interleaved.
- Sits directly upstream of ethernet_frame_parser. Drives its s_axis_* inputs and tags each frame with the source port ID.
- Provides a per-port enable mask and a frame-done pulse for statistics logic.

Parameters:
- DATA_WIDTH, 64, tdata width in bits. Must match the downstream parser.
- NUM_PORTS, 4, number of ingress requesters. Legal range 2..16.
- PORT_W, $clog2(NUM_PORTS), port ID width. Derived; not overridden.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  packed port data; port i is slice [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tready  out  NUM_PORTS  per-port ready
- s_axis_tlast  in  NUM_PORTS  per-port last
- port_enable  in  NUM_PORTS  1 = port may win arbitration
- m_axis_tdata  out  DATA_WIDTH  to parser
- m_axis_tvalid  out  1  to parser
- m_axis_tready  in  1  from parser
- m_axis_tlast  out  1  to parser
- m_axis_tid  out  PORT_W  port ID of the current frame; stable for the whole frame
- grant_active  out  1  high while in state LOCK
- frame_done  out  1  one-cycle pulse, registered, the cycle after a tlast beat is accepted
- frame_done_port  out  PORT_W  port ID for frame_done; holds its value between pulses

Behaviour:
- Reset (async assert, sync deassert handled externally). All of the following are 0: state=IDLE, rr_ptr, grant index, m_axis_tid, grant_active, frame_done, frame_done_port, all s_axis_tready, m_axis_tvalid. Reset mid-frame abandons the frame with no flush; upstream is responsible for re-framing.
- States: IDLE, LOCK.
- IDLE, request vector: req = s_axis_tvalid & port_enable.
  - If req != 0, pick the first set bit at or above rr_ptr, wrapping modulo NUM_PORTS.
  - Register the winner into grant/m_axis_tid, set rr_ptr = (winner+1) mod NUM_PORTS, go to LOCK.
  - No beat transfers in IDLE: all s_axis_tready=0 and m_axis_tvalid=0. This gives exactly one bubble cycle per frame.
- LOCK, combinational pass-through from port g:
  - m_axis_tdata = s_axis_tdata[g], m_axis_tvalid = s_axis_tvalid[g], m_axis_tlast = s_axis_tlast[g].
  - s_axis_tready[g] = m_axis_tready. All other s_axis_tready bits = 0.
  - Beat accept = m_axis_tvalid & m_axis_tready.
  - Accept with tlast: go to IDLE next cycle and pulse frame_done with frame_done_port=g.
  - tvalid gaps on port g mid-frame keep the grant. There is no timeout.
- port_enable is sampled only in IDLE. Clearing the granted port's enable mid-frame does not truncate the frame.
- Single-beat frame (tlast on the first beat): LOCK lasts 1 cycle. Sustained throughput is 1 beat per 2 cycles in this case.
- Back-to-back: after a tlast accept, IDLE re-arbitrates in the next cycle. The same port wins again only if no other enabled port is requesting.
- m_axis_tdata/m_axis_tlast are don't-care when m_axis_tvalid=0. Implementation drives 0 in IDLE.
- No AXI-stability violations: in LOCK, outputs are pure functions of port g's inputs.

Decomposition:
- eth_parser_pkg gains:
  - arb_state_t enum {ARB_IDLE, ARB_LOCK}
  - localparam MAX_INGRESS_PORTS = 16
- Sub-module rr_priority_picker (combinational, params N/W).
  - Inputs: req[N], ptr[W].
  - Outputs: found, idx[W].
  - Implemented with a double-width masked priority encode.
- The top holds the FSM, the grant/rr_ptr registers and the data mux.

Test Plan:
- Reset → all outputs 0, state IDLE. Assert rst_n low during a LOCK frame on port 2 → next edge: tready all 0, m_axis_tvalid=0, m_axis_tid=0.
- Ports 0..3 each present a 3-beat frame simultaneously with m_axis_tready=1 → frames emerge in order 0,1,2,3, each preceded by one bubble. frame_done pulses 4 times with ports 0,1,2,3.
- Only port 2 requests, with 5 back-to-back 1-beat frames → port 2 is granted 5 times, m_axis_tid=2 each time, 10 cycles total.
- Port 1 frame of 4 beats with m_axis_tready toggling 1,0 and tvalid gap cycles → exactly 4 beats out, data in order, other ports' tready stay 0 throughout.
- port_enable=4'b1101 with all ports requesting → port 1 is never granted. Deassert enable[0] during port 0's frame → the frame completes fully, then port 0 is skipped.
- rr_ptr wrap: NUM_PORTS=4, last grant = 3, requests on ports 0 and 3 → port 0 wins next.
